mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 20 ++
 rtl/w_pipe_reg.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared constants and types for the memory stage controller
package mem_stage_ctrl_pkg;

  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam int         OP_MSB = 31;
  localparam int         OP_LSB = 27;
  localparam int         MEM_AW = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/w_pipe_reg.sv
// rtl/w_pipe_reg.sv - writeback-stage pipeline register with enable and async active-low clear
module w_pipe_reg (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  input  logic [31:0] d_data,
  input  logic [31:0] d_insn,
  input  logic        d_ovf,
  input  logic        d_valid,
  output logic [31:0] q_data,
  output logic [31:0] q_insn,
  output logic        q_ovf,
  output logic        q_valid
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_data  <= '0;
      q_insn  <= '0;
      q_ovf   <= 1'b0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_data  <= d_data;
      q_insn  <= d_insn;
      q_ovf   <= d_ovf;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - M-stage controller: lw/sw decode, data-memory handshake, W-stage feed
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       m_data_o,
  input  logic [31:0]       m_data_d,
  input  logic [31:0]       m_insn,
  input  logic              m_ovf,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       w_data,
  output logic [31:0]       w_insn,
  output logic              w_ovf,
  output logic              w_valid
);

  state_t      state;
  logic [31:0] load_q;
  logic [4:0]  opcode;
  logic        is_lw;
  logic        is_sw;
  logic        is_mem;

  logic [31:0] nxt_data;
  logic [31:0] nxt_insn;
  logic        nxt_ovf;
  logic        nxt_valid;

  assign opcode = insn_opcode(m_insn);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_mem = is_lw | is_sw;

  // Request outputs are latched on entry to ACCESS so they cannot move until the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            state     <= ST_ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= is_sw;
            mem_addr  <= m_data_o[MEM_AW-1:0];
            mem_wdata <= m_data_d;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_lw) begin
              load_q <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the stage never asserts stall while held in reset.
  always_comb begin
    stall = reset & (((state == ST_IDLE) & is_mem) | (state == ST_ACCESS));
  end

  always_comb begin
    nxt_data  = '0;
    nxt_insn  = '0;
    nxt_ovf   = 1'b0;
    nxt_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!is_mem) begin
          nxt_data  = m_data_o;
          nxt_insn  = m_insn;
          nxt_ovf   = m_ovf;
          nxt_valid = (m_insn != 32'd0);
        end
      end
      ST_DONE: begin
        nxt_data  = is_lw ? load_q : m_data_o;
        nxt_insn  = m_insn;
        nxt_ovf   = m_ovf;
        nxt_valid = 1'b1;
      end
      default: begin
        nxt_data  = '0;
        nxt_insn  = '0;
        nxt_ovf   = 1'b0;
        nxt_valid = 1'b0;
      end
    endcase
  end

  w_pipe_reg u_w_pipe_reg (
    .clk     (clk),
    .clr_n   (reset),
    .en      (1'b1),
    .d_data  (nxt_data),
    .d_insn  (nxt_insn),
    .d_ovf   (nxt_ovf),
    .d_valid (nxt_valid),
    .q_data  (w_data),
    .q_insn  (w_insn),
    .q_ovf   (w_ovf),
    .q_valid (w_valid)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_o;
  logic [31:0] m_data_d;
  logic [31:0] m_insn;
  logic        m_ovf;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] w_data;
  logic [31:0] w_insn;
  logic        w_ovf;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] insn;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] data_o;
    logic [31:0] data_d;
    logic        ovf;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [11:0] exp_addr;
    logic        exp_we;
    int          exp_stall;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  mem_stage_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .m_data_o  (m_data_o),
    .m_data_d  (m_data_d),
    .m_insn    (m_insn),
    .m_ovf     (m_ovf),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .w_data    (w_data),
    .w_insn    (w_insn),
    .w_ovf     (w_ovf),
    .w_valid   (w_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid W result must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (reset && w_valid) begin
      if (exp_q.size() == 0) begin
        chk("w_unexpected_valid", {31'd0, w_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("w_data", w_data, e.data);
        chk("w_insn", w_insn, e.insn);
        chk("w_ovf", {31'd0, w_ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic apply_vec(input vec_t v);
    int stall_cnt;
    int acc_cnt;
    int guard;
    m_insn    = v.insn;
    m_data_o  = v.data_o;
    m_data_d  = v.data_d;
    m_ovf     = v.ovf;
    mem_ack   = 1'b0;
    if (v.insn != 32'd0) exp_q.push_back({v.exp_data, v.insn, v.ovf});
    stall_cnt = 0;
    acc_cnt   = 0;
    guard     = 0;
    #1;
    while (stall && guard < 50) begin
      stall_cnt++;
      if (mem_req) begin
        acc_cnt++;
        chk("mem_addr", {20'd0, mem_addr}, {20'd0, v.exp_addr});
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
        if (v.exp_we) chk("mem_wdata", mem_wdata, v.data_d);
        if (acc_cnt == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      #1;
      guard++;
    end
    chk("stall_timeout", {31'd0, guard >= 50}, 32'd0);
    chk("stall_cycles", stall_cnt, v.exp_stall);
    chk("req_after_done", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // insn, data_o, data_d, ovf, ack delay, rdata, exp w_data, exp addr, exp we, exp stall cycles
    vecs[0] = '{32'h0022_1800, 32'h0000_002A, 32'h0,         1'b1, 0, 32'h0,         32'h0000_002A, 12'h000, 1'b0, 0};
    vecs[1] = '{32'h4000_0001, 32'h0000_1005, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 12'h005, 1'b0, 2};
    vecs[2] = '{32'h3800_0002, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 4, 32'h1111_1111, 32'h0000_0010, 12'h010, 1'b1, 5};
    vecs[3] = '{32'h4000_0003, 32'hFFFF_FFFF, 32'h0,         1'b1, 2, 32'h1234_5678, 32'h1234_5678, 12'hFFF, 1'b0, 3};
    vecs[4] = '{32'h3800_0004, 32'h0000_1000, 32'h0BAD_CAFE, 1'b0, 1, 32'h0,         32'h0000_1000, 12'h000, 1'b1, 2};
    vecs[5] = '{32'h0000_0000, 32'h0000_0055, 32'h0,         1'b0, 0, 32'h0,         32'h0000_0055, 12'h000, 1'b0, 0};
    vecs[6] = '{32'h0800_0000, 32'h0000_0007, 32'h0,         1'b0, 0, 32'h0,         32'h0000_0007, 12'h000, 1'b0, 0};
    vecs[7] = '{32'h4000_0007, 32'h0000_0020, 32'h0,         1'b0, 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 12'h020, 1'b0, 2};

    reset     = 1'b0;
    m_insn    = 32'h4000_0000;
    m_data_o  = 32'h0000_0123;
    m_data_d  = 32'h0;
    m_ovf     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_w_insn", w_insn, 32'd0);
    m_insn = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Spurious ack while idle with a pass-through instruction.
    m_insn   = 32'h0022_1800;
    m_data_o = 32'h0000_0099;
    m_ovf    = 1'b0;
    exp_q.push_back({32'h0000_0099, 32'h0022_1800, 1'b0});
    mem_ack  = 1'b1;
    #1;
    chk("spur_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    m_insn  = 32'd0;
    #1;
    chk("spur_mem_req", {31'd0, mem_req}, 32'd0);
    chk("spur_stall_after", {31'd0, stall}, 32'd0);
    @(negedge clk);

    // Reset in the middle of an access abandons it.
    m_insn   = 32'h4000_0009;
    m_data_o = 32'h0000_0030;
    begin
      int guard;
      guard = 0;
      while (!mem_req && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      chk("mid_rst_req_seen", {31'd0, mem_req}, 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("mid_rst_w_valid", {31'd0, w_valid}, 32'd0);
    m_insn = 32'd0;
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stale_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stale_ack_stall", {31'd0, stall}, 32'd0);
    chk("stale_ack_w_valid", {31'd0, w_valid}, 32'd0);
    @(negedge clk);
    apply_vec(vecs[7]);

    m_insn = 32'd0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
